// File: rtl/ddos_cnt_rmw.sv
// Per-flow request counter that does a read-modify-write on an external 32-bit RAM.
// It wipes the table after reset and on request. Define DDOS_CNT_SATURATE_EN to make counts saturate instead of wrap.
module ddos_cnt_rmw #(
   parameter int MAX_DEPTH_BITS = 14
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      req_valid,
   input  logic [MAX_DEPTH_BITS-1:0] req_index,
   output logic                      req_ready,
   input  logic [31:0]               threshold,
   input  logic                      clear_start,
   output logic                      clear_busy,
   output logic                      alert_valid,
   output logic [MAX_DEPTH_BITS-1:0] alert_index,
   output logic [31:0]               alert_count,
   output logic                      mem_wr_en,
   output logic [MAX_DEPTH_BITS-1:0] mem_addr,
   output logic [31:0]               mem_wr_data,
   input  logic [31:0]               mem_rd_data
);

   typedef enum logic [1:0] {CLEAR, IDLE, RD, WR} state_t;

   localparam logic [MAX_DEPTH_BITS-1:0] SWEEP_LAST = '1;

   state_t                    state, state_nxt;
   logic [MAX_DEPTH_BITS-1:0] sweep_addr, sweep_nxt;
   logic [MAX_DEPTH_BITS-1:0] lat_index, lat_nxt;
   logic [MAX_DEPTH_BITS-1:0] alert_index_q;
   logic [31:0]               alert_count_q;
   logic [31:0]               new_count;
   logic                      hit;

   // A saturated entry must not fire again, so an alert needs the count to actually change.
   always_comb begin
`ifdef DDOS_CNT_SATURATE_EN
      new_count = (mem_rd_data == 32'hFFFF_FFFF) ? mem_rd_data : mem_rd_data + 32'd1;
      hit       = (threshold != 32'd0) && (new_count == threshold) &&
                  (mem_rd_data != 32'hFFFF_FFFF);
`else
      new_count = mem_rd_data + 32'd1;
      hit       = (threshold != 32'd0) && (new_count == threshold);
`endif
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state         <= CLEAR;
         sweep_addr    <= '0;
         lat_index     <= '0;
         alert_index_q <= '0;
         alert_count_q <= '0;
      end else begin
         state      <= state_nxt;
         sweep_addr <= sweep_nxt;
         lat_index  <= lat_nxt;
         if (state == WR && hit) begin
            alert_index_q <= lat_index;
            alert_count_q <= new_count;
         end
      end
   end

   // Outputs are decoded from state; reset overrides them so nothing is written while it is held.
   always_comb begin
      state_nxt   = state;
      sweep_nxt   = sweep_addr;
      lat_nxt     = lat_index;
      req_ready   = 1'b0;
      clear_busy  = 1'b0;
      alert_valid = 1'b0;
      alert_index = alert_index_q;
      alert_count = alert_count_q;
      mem_wr_en   = 1'b0;
      mem_addr    = '0;
      mem_wr_data = 32'd0;
      case (state)
         CLEAR: begin
            clear_busy = 1'b1;
            mem_wr_en  = 1'b1;
            mem_addr   = sweep_addr;
            if (sweep_addr == SWEEP_LAST) begin
               state_nxt = IDLE;
               sweep_nxt = '0;
            end else begin
               sweep_nxt = sweep_addr + 1'b1;
            end
         end
         IDLE: begin
            req_ready = 1'b1;
            if (clear_start) begin
               state_nxt = CLEAR;
               sweep_nxt = '0;
            end else if (req_valid) begin
               lat_nxt   = req_index;
               state_nxt = RD;
            end
         end
         RD: begin
            mem_addr  = lat_index;
            state_nxt = WR;
         end
         WR: begin
            mem_wr_en   = 1'b1;
            mem_addr    = lat_index;
            mem_wr_data = new_count;
            state_nxt   = IDLE;
            if (hit) begin
               alert_valid = 1'b1;
               alert_index = lat_index;
               alert_count = new_count;
            end
         end
         default: state_nxt = CLEAR;
      endcase
      if (reset) begin
         req_ready   = 1'b0;
         clear_busy  = 1'b1;
         alert_valid = 1'b0;
         alert_index = '0;
         alert_count = 32'd0;
         mem_wr_en   = 1'b0;
         mem_addr    = '0;
         mem_wr_data = 32'd0;
      end
   end

endmodule

// File: tb/tb_ddos_cnt_rmw.sv
// Scoreboard bench for ddos_cnt_rmw with a small behavioural RAM.
// Stimulus changes 1ns after the rising edge, and the monitors sample on the falling edge.
module tb_ddos_cnt_rmw;

   localparam int W = 4;
   localparam int N = 16;

   logic          clk = 1'b0;
   logic          reset = 1'b1;
   logic          req_valid = 1'b0;
   logic [W-1:0]  req_index = '0;
   logic          req_ready;
   logic [31:0]   threshold = 32'd0;
   logic          clear_start = 1'b0;
   logic          clear_busy;
   logic          alert_valid;
   logic [W-1:0]  alert_index;
   logic [31:0]   alert_count;
   logic          mem_wr_en;
   logic [W-1:0]  mem_addr;
   logic [31:0]   mem_wr_data;
   logic [31:0]   mem_rd_data;

   logic          pre_en = 1'b0;
   logic [W-1:0]  pre_addr = '0;
   logic [31:0]   pre_data = 32'd0;
   logic [31:0]   tb_mem [N];

   typedef struct {
      logic [W-1:0] addr;
      logic [31:0]  data;
   } txn_t;

   txn_t        exp_wr [$];
   txn_t        exp_al [$];
   logic [31:0] model_cnt [N];
   int          checks = 0;
   int          errors = 0;

   ddos_cnt_rmw #(.MAX_DEPTH_BITS(W)) dut (
      .clk         (clk),
      .reset       (reset),
      .req_valid   (req_valid),
      .req_index   (req_index),
      .req_ready   (req_ready),
      .threshold   (threshold),
      .clear_start (clear_start),
      .clear_busy  (clear_busy),
      .alert_valid (alert_valid),
      .alert_index (alert_index),
      .alert_count (alert_count),
      .mem_wr_en   (mem_wr_en),
      .mem_addr    (mem_addr),
      .mem_wr_data (mem_wr_data),
      .mem_rd_data (mem_rd_data)
   );

   always #5 clk = ~clk;

   // The RAM registers its read data and returns the old contents when the same address is written.
   always @(posedge clk) begin
      if (mem_wr_en) tb_mem[mem_addr] <= mem_wr_data;
      else if (pre_en) tb_mem[pre_addr] <= pre_data;
      mem_rd_data <= tb_mem[mem_addr];
   end

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s actual=%0h expected=%0h", name, actual, expected);
      end
   endtask

   // Write monitor: every RAM write must match the head of the expected queue.
   always @(negedge clk) begin
      if (mem_wr_en === 1'b1) begin
         if (exp_wr.size() == 0) begin
            checkOutput("unexpected_write_addr", {28'd0, mem_addr}, 32'hDEAD);
         end else begin
            txn_t e;
            e = exp_wr.pop_front();
            checkOutput("write_addr", {28'd0, mem_addr}, {28'd0, e.addr});
            checkOutput("write_data", mem_wr_data, e.data);
         end
      end
   end

   // Alert monitor: every alert strobe must match the head of the expected alert queue.
   always @(negedge clk) begin
      if (alert_valid === 1'b1) begin
         if (exp_al.size() == 0) begin
            checkOutput("unexpected_alert", {28'd0, alert_index}, 32'hDEAD);
         end else begin
            txn_t e;
            e = exp_al.pop_front();
            checkOutput("alert_index", {28'd0, alert_index}, {28'd0, e.addr});
            checkOutput("alert_count", alert_count, e.data);
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic pushSweep();
      for (int i = 0; i < N; i++) begin
         exp_wr.push_back('{addr: W'(i), data: 32'd0});
         model_cnt[i] = 32'd0;
      end
   endtask

   task automatic waitIdle(input string name);
      int n = 0;
      while (req_ready !== 1'b1 && n < 100) begin
         tick();
         n++;
      end
      checkOutput(name, {31'd0, req_ready}, 32'd1);
   endtask

   function automatic logic [31:0] incModel(input logic [31:0] v);
`ifdef DDOS_CNT_SATURATE_EN
      return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
`else
      return v + 32'd1;
`endif
   endfunction

   // A single request: wait for ready, hold it over one edge, then let RD and WR finish.
   task automatic applyStimulus(input logic [W-1:0] idx, input bit expect_alert);
      txn_t t;
      waitIdle("ready_before_req");
      req_valid = 1'b1;
      req_index = idx;
      model_cnt[idx] = incModel(model_cnt[idx]);
      t = '{addr: idx, data: model_cnt[idx]};
      exp_wr.push_back(t);
      if (expect_alert) exp_al.push_back(t);
      tick();
      req_valid = 1'b0;
      tick();
      tick();
   endtask

   initial begin
      #200000;
      $display("[TB] FAIL watchdog actual=timeout expected=finish");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      int n;
      int acc;
      int last;

      // Reset state and the initial sweep.
      pushSweep();
      tick();
      tick();
      checkOutput("rst_req_ready", {31'd0, req_ready}, 32'd0);
      checkOutput("rst_clear_busy", {31'd0, clear_busy}, 32'd1);
      checkOutput("rst_mem_wr_en", {31'd0, mem_wr_en}, 32'd0);
      checkOutput("rst_mem_addr", {28'd0, mem_addr}, 32'd0);
      checkOutput("rst_alert_valid", {31'd0, alert_valid}, 32'd0);
      checkOutput("rst_alert_count", alert_count, 32'd0);
      checkOutput("rst_alert_index", {28'd0, alert_index}, 32'd0);
      reset = 1'b0;
      n = 0;
      while (clear_busy === 1'b1 && n < 100) begin
         tick();
         n++;
      end
      checkOutput("sweep_busy_cycles", n, 16);
      checkOutput("ready_after_sweep", {31'd0, req_ready}, 32'd1);

      // Three hits on index 5 reach the threshold exactly once; the fourth hit does not alert.
      threshold = 32'd3;
      applyStimulus(4'd5, 1'b0);
      applyStimulus(4'd5, 1'b0);
      applyStimulus(4'd5, 1'b1);
      applyStimulus(4'd5, 1'b0);
      checkOutput("alert_index_held", {28'd0, alert_index}, 32'd5);
      checkOutput("alert_count_held", alert_count, 32'd3);

      // An all-ones entry wraps, or saturates when the macro is defined.
      waitIdle("ready_before_preload");
      pre_en = 1'b1;
      pre_addr = 4'd7;
      pre_data = 32'hFFFF_FFFF;
      tick();
      pre_en = 1'b0;
      model_cnt[7] = 32'hFFFF_FFFF;
      applyStimulus(4'd7, 1'b0);
`ifdef DDOS_CNT_SATURATE_EN
      checkOutput("ram_entry7", tb_mem[7], 32'hFFFF_FFFF);
`else
      checkOutput("ram_entry7", tb_mem[7], 32'd0);
`endif

      // Continuous requests alternating between indexes 1 and 2 are accepted every third cycle.
      threshold = 32'd0;
      waitIdle("ready_before_stream");
      req_valid = 1'b1;
      acc = 0;
      last = -3;
      for (int c = 0; c < 18; c++) begin
         req_index = (acc % 2 == 0) ? 4'd1 : 4'd2;
         if (req_ready === 1'b1) begin
            checkOutput("stream_gap", c - last, 3);
            last = c;
            model_cnt[req_index] = incModel(model_cnt[req_index]);
            exp_wr.push_back('{addr: req_index, data: model_cnt[req_index]});
            acc++;
         end
         tick();
      end
      req_valid = 1'b0;
      checkOutput("stream_accepts", acc, 6);

      // clear_start wins over a simultaneous request.
      waitIdle("ready_before_clear");
      pushSweep();
      clear_start = 1'b1;
      req_valid = 1'b1;
      req_index = 4'd9;
      tick();
      clear_start = 1'b0;
      req_valid = 1'b0;
      checkOutput("clear_busy_started", {31'd0, clear_busy}, 32'd1);
      checkOutput("clear_no_ready", {31'd0, req_ready}, 32'd0);
      waitIdle("ready_after_clear");

      // clear_start arriving during RD is ignored.
      req_valid = 1'b1;
      req_index = 4'd3;
      model_cnt[3] = incModel(model_cnt[3]);
      exp_wr.push_back('{addr: 4'd3, data: model_cnt[3]});
      tick();
      req_valid = 1'b0;
      clear_start = 1'b1;
      tick();
      clear_start = 1'b0;
      checkOutput("clear_ignored_busy", {31'd0, clear_busy}, 32'd0);
      tick();
      checkOutput("clear_ignored_ready", {31'd0, req_ready}, 32'd1);

      // Reset arriving in the WR state of a request to index 2 abandons that write.
      req_valid = 1'b1;
      req_index = 4'd2;
      tick();
      req_valid = 1'b0;
      tick();
      reset = 1'b1;
      pushSweep();
      tick();
      checkOutput("rst2_mem_wr_en", {31'd0, mem_wr_en}, 32'd0);
      checkOutput("rst2_clear_busy", {31'd0, clear_busy}, 32'd1);
      tick();
      reset = 1'b0;
      checkOutput("rst2_sweep_start_addr", {28'd0, mem_addr}, 32'd0);
      waitIdle("ready_after_rst2");
      checkOutput("ram_entry2_after_rst", tb_mem[2], 32'd0);

      tick();
      tick();
      checkOutput("pending_writes", exp_wr.size(), 0);
      checkOutput("pending_alerts", exp_al.size(), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/ddos_cnt_rmw.md
DDOS_CNT_RMW -- requirements
Module: ddos_cnt_rmw

Interface
REQ-001 SHALL have parameter MAX_DEPTH_BITS, default 14, the counter-table address width; the table holds 2**MAX_DEPTH_BITS 32-bit entries.
REQ-002 SHALL use one clock and an asynchronous, active-high reset; ports are named clk and reset.
REQ-003 clk  input  1  the sole clock; all logic is rising-edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 req_valid  input  1  a count request is present.
REQ-006 req_index  input  MAX_DEPTH_BITS  flow-hash index to increment.
REQ-007 req_ready  output  1  the block accepts a request this cycle.
REQ-008 threshold  input  32  alert threshold; 0 disables alerts.
REQ-009 clear_start  input  1  single-cycle pulse requesting a table wipe.
REQ-010 clear_busy  output  1  a table wipe is in progress.
REQ-011 alert_valid  output  1  single-cycle alert strobe.
REQ-012 alert_index  output  MAX_DEPTH_BITS  index that hit the threshold.
REQ-013 alert_count  output  32  count value written for that index.
REQ-014 mem_wr_en  output  1  write enable to the counter RAM.
REQ-015 mem_addr  output  MAX_DEPTH_BITS  RAM address.
REQ-016 mem_wr_data  output  32  RAM write data.
REQ-017 mem_rd_data  input  32  RAM registered read data, valid one clk after mem_addr is presented.

Function
REQ-018 The FSM SHALL have four states: CLEAR, IDLE, RD and WR.
REQ-019 In CLEAR, the block SHALL assert mem_wr_en with mem_wr_data=0 and a sweep address running 0..2**MAX_DEPTH_BITS-1, one entry per cycle, with clear_busy=1 and req_ready=0.
REQ-020 CLEAR SHALL go to IDLE on the cycle after the last address is written.
REQ-021 In IDLE, req_ready SHALL be 1 and mem_wr_en SHALL be 0.
REQ-022 In IDLE, if clear_start=1, the block SHALL go to CLEAR with sweep address 0; clear_start takes priority over req_valid in the same cycle, and no request is accepted.
REQ-023 In IDLE, if req_valid=1 and clear_start=0, the block SHALL latch req_index and go to RD.
REQ-024 In RD, mem_addr SHALL be the latched index, mem_wr_en SHALL be 0 and req_ready SHALL be 0; the next state is WR.
REQ-025 In WR, the block SHALL drive mem_wr_en=1, mem_addr=the latched index and mem_wr_data=mem_rd_data+1, then go to IDLE.
REQ-026 Throughput SHALL be one request per 3 cycles; back-to-back requests to the same index SHALL each see the prior write, because RD follows that WR.
REQ-027 In WR, if threshold!=0 and the new count==threshold, alert_valid SHALL pulse high for exactly that one cycle, with alert_index=the latched index and alert_count=the new count; an alert fires once per crossing.
REQ-028 alert_index and alert_count SHALL hold their values until the next alert.
REQ-029 clear_start outside IDLE SHALL be ignored.
REQ-030 Without the configuration macro, a count of 0xFFFFFFFF SHALL wrap to 0 on increment.

Reset
REQ-031 While reset=1, the block SHALL force state=CLEAR, sweep address=0, and the outputs req_ready=0, alert_valid=0, alert_index=0, alert_count=0, mem_wr_en=0, mem_addr=0, mem_wr_data=0 and clear_busy=1.
REQ-032 After reset deasserts, the sweep SHALL begin on the first clk edge.
REQ-033 Reset asserted during RD or WR SHALL abandon the request: no write completes after reset, and the table is re-zeroed.

Configuration
REQ-034 With macro DDOS_CNT_SATURATE_EN defined, an increment from 0xFFFFFFFF SHALL write 0xFFFFFFFF, and an alert SHALL NOT re-fire at saturation unless threshold==0xFFFFFFFF is newly reached.
REQ-035 Without DDOS_CNT_SATURATE_EN, counts SHALL wrap per REQ-030.

Verification
REQ-036 Release reset with MAX_DEPTH_BITS=4 -> 16 consecutive writes of 0 to addr 0..15, clear_busy=1 for 16 cycles, then req_ready=1.
REQ-037 Send 3 requests to index 5 with threshold=3 -> writes of 1, 2 and 3 to addr 5; a single alert_valid pulse with alert_index=5 and alert_count=3.
REQ-038 Send a 4th request to index 5 -> a write of 4 and no alert.
REQ-039 Preload entry 7 with 0xFFFFFFFF and request index 7 -> a write of 0 without the macro, or 0xFFFFFFFF with DDOS_CNT_SATURATE_EN.
REQ-040 Hold req_valid=1 with indexes 1,2 continuously -> req_ready high one cycle in three, and each index is written exactly once per acceptance.
REQ-041 Assert reset in WR of a request to index 2 -> no write to 2 with data 1 after reset; a full sweep restarts at addr 0.
